// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two-requester request/response handshake of alu_arbiter.
// Slot k of every 2-bit vector belongs to requester k; operand buses carry
// requester k's N-bit sign-magnitude value in [k*N +: N].
//   i_req_valid / o_req_ready  : request handshake, one bit per requester
//   i_req_op                   : per requester, 0 = a-b, 1 = a+b
//   i_req_a / i_req_b          : packed operands for both requesters
//   o_rsp_valid / i_rsp_ready  : response handshake, one bit per requester
//   o_rsp_data / o_rsp_carry   : shared sign-magnitude result and overflow
//   o_busy                     : arbiter is not idle
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int N = 8
);
  logic [1:0]     i_req_valid;
  logic [1:0]     o_req_ready;
  logic [1:0]     i_req_op;
  logic [2*N-1:0] i_req_a;
  logic [2*N-1:0] i_req_b;
  logic [1:0]     o_rsp_valid;
  logic [1:0]     i_rsp_ready;
  logic [N-1:0]   o_rsp_data;
  logic           o_rsp_carry;
  logic           o_busy;

  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_carry, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_carry, o_busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two requesters share one sign-magnitude subtract unit. Addition is done by
// flipping B's sign before capture. A small IDLE -> EXEC -> RESP FSM serves
// one operation at a time; simultaneous requests are resolved round-robin.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : alu_arbiter_if.slave (request/response handshake, result, busy)
// -----------------------------------------------------------------------------

// Sign-magnitude a - b. Magnitudes are N-1 bits; carry only arises when the
// magnitudes are summed (operand signs differ). Negative zero is not
// normalised.
module sm_sub #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         carry_o
);
  localparam int M = N - 1;

  logic         sign_a, sign_b;
  logic [M-1:0] mag_a, mag_b;
  logic [M:0]   mag_sum;

  assign sign_a  = a_i[N-1];
  assign sign_b  = b_i[N-1];
  assign mag_a   = a_i[M-1:0];
  assign mag_b   = b_i[M-1:0];
  assign mag_sum = {1'b0, mag_a} + {1'b0, mag_b};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches leaves it unassigned and no latch is inferred.
  always_comb begin
    diff_o  = '0;
    carry_o = 1'b0;
    if (sign_a != sign_b) begin
      diff_o  = {sign_a, mag_sum[M-1:0]};
      carry_o = mag_sum[M];
    end else if (mag_a >= mag_b) begin
      diff_o = {sign_a, mag_a - mag_b};
    end else begin
      diff_o = {~sign_a, mag_b - mag_a};
    end
  end
endmodule

module alu_arbiter #(
  parameter int N = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         owner_q, owner_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] data_q, data_d;
  logic         carry_q, carry_d;

  logic         grant_id;
  logic [1:0]   grant_oh;
  logic [1:0]   req_ready;
  logic         req_fire;
  logic         rsp_fire;
  logic [N-1:0] sel_a, sel_b;
  logic         sel_op;
  logic [N-1:0] sub_diff;
  logic         sub_carry;

  // Single valid wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    grant_id = 1'b0;
    if (bus.i_req_valid == 2'b10)      grant_id = 1'b1;
    else if (bus.i_req_valid == 2'b11) grant_id = ptr_q;
  end

  assign grant_oh = (bus.i_req_valid == 2'b00) ? 2'b00 :
                    (grant_id ? 2'b10 : 2'b01);
  // Gated by i_rst_n so ready drops the instant reset asserts, not at an edge.
  assign req_ready = (state_q == IDLE && i_rst_n) ? grant_oh : 2'b00;
  assign req_fire  = |(bus.i_req_valid & req_ready);
  assign rsp_fire  = (state_q == RESP) && bus.i_rsp_ready[owner_q];

  assign sel_a  = grant_id ? bus.i_req_a[2*N-1:N] : bus.i_req_a[N-1:0];
  assign sel_b  = grant_id ? bus.i_req_b[2*N-1:N] : bus.i_req_b[N-1:0];
  assign sel_op = bus.i_req_op[grant_id];

  sm_sub #(.N(N)) u_sub (
    .a_i     (a_q),
    .b_i     (b_q),
    .diff_o  (sub_diff),
    .carry_o (sub_carry)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          a_d     = sel_a;
          // a + b is computed as a - (-b).
          b_d     = {sel_b[N-1] ^ sel_op, sel_b[N-2:0]};
          owner_d = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = sub_diff;
        carry_d = sub_carry;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others. The operand registers are reset
  // too; they are a handful of flops, not a memory array.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_rsp_data  = data_q;
  assign bus.o_rsp_carry = carry_q;
  assign bus.o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed testbench for alu_arbiter with N = 8. Every task starts and ends in
// the low phase of the clock; outputs are sampled after the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] last_data  = 8'h00;
  logic       last_carry = 1'b0;

  alu_arbiter_if #(.N(N)) bus ();

  alu_arbiter #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // One complete transaction on requester k with the response already ready,
  // so it is accepted, computed and consumed in three edges.
  task automatic run_op(input int k, input logic op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_d,
                        input logic exp_c, input string name);
    logic [1:0] oh;
    oh = (k == 1) ? 2'b10 : 2'b01;
    bus.i_req_valid = oh;
    bus.i_req_op    = (k == 1) ? {op, ~op} : {~op, op};
    bus.i_req_a     = (k == 1) ? {a, ~a} : {~a, a};
    bus.i_req_b     = (k == 1) ? {b, ~b} : {~b, b};
    bus.i_rsp_ready = oh;
    #1;
    checks++;
    if (bus.o_req_ready !== oh) begin
      errors++;
      $display("FAIL %s req_ready: got %b expected %b", name, bus.o_req_ready, oh);
    end
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 2'b00;
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL %s exec state: got busy=%b rsp_valid=%b expected busy=1 rsp_valid=00",
               name, bus.o_busy, bus.o_rsp_valid);
    end
    checks++;
    if (bus.o_rsp_data !== last_data || bus.o_rsp_carry !== last_carry) begin
      errors++;
      $display("FAIL %s exec hold: got data=%h carry=%b expected data=%h carry=%b",
               name, bus.o_rsp_data, bus.o_rsp_carry, last_data, last_carry);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_rsp_valid !== oh) begin
      errors++;
      $display("FAIL %s rsp_valid: got %b expected %b", name, bus.o_rsp_valid, oh);
    end
    checks++;
    if (bus.o_rsp_data !== exp_d || bus.o_rsp_carry !== exp_c) begin
      errors++;
      $display("FAIL %s result: got data=%h carry=%b expected data=%h carry=%b",
               name, bus.o_rsp_data, bus.o_rsp_carry, exp_d, exp_c);
    end
    last_data  = exp_d;
    last_carry = exp_c;
    @(posedge clk);
    @(negedge clk);
    bus.i_rsp_ready = 2'b00;
    checks++;
    if (bus.o_rsp_valid !== 2'b00 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s return to idle: got rsp_valid=%b busy=%b expected 00/0",
               name, bus.o_rsp_valid, bus.o_busy);
    end
  endtask

  task automatic test_reset();
    bus.i_req_valid = 2'b11;
    bus.i_req_op    = 2'b00;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_rsp_ready = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_req_ready !== 2'b00 || bus.o_rsp_valid !== 2'b00 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset handshake: got ready=%b rsp_valid=%b busy=%b expected 00/00/0",
               bus.o_req_ready, bus.o_rsp_valid, bus.o_busy);
    end
    checks++;
    if (bus.o_rsp_data !== 8'h00 || bus.o_rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset result: got data=%h carry=%b expected 00/0",
               bus.o_rsp_data, bus.o_rsp_carry);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.o_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset release ready: got %b expected 01", bus.o_req_ready);
    end
    bus.i_req_valid = 2'b00;
    last_data  = 8'h00;
    last_carry = 1'b0;
  endtask

  task automatic test_basic_sub();
    run_op(0, 1'b0, 8'h05, 8'h03, 8'h02, 1'b0, "sub_5_3");
  endtask

  task automatic test_add_neg();
    run_op(1, 1'b1, 8'h85, 8'h03, 8'h82, 1'b0, "add_m5_3");
    run_op(0, 1'b0, 8'h85, 8'h85, 8'h80, 1'b0, "sub_negzero");
  endtask

  task automatic test_carry();
    run_op(0, 1'b1, 8'h7F, 8'h01, 8'h00, 1'b1, "add_carry");
  endtask

  // run_op returns on the falling edge right after the response handshake, so
  // chaining calls issues the next request at the minimum 3-cycle interval.
  task automatic test_back_to_back();
    run_op(1, 1'b0, 8'h03, 8'h05, 8'h82, 1'b0, "b2b_sub_3_5");
    run_op(0, 1'b1, 8'h86, 8'h04, 8'h82, 1'b0, "b2b_add_m6_4");
    run_op(1, 1'b0, 8'h84, 8'h02, 8'h86, 1'b0, "b2b_sub_m4_2");
  endtask

  task automatic test_backpressure();
    bus.i_req_valid = 2'b10;
    bus.i_req_op    = 2'b01;
    bus.i_req_a     = {8'h10, 8'h00};
    bus.i_req_b     = {8'h83, 8'h00};
    bus.i_rsp_ready = 2'b00;
    @(posedge clk);
    @(negedge clk);
    // requester 0 now waits, and the non-owner ready bit is driven high
    bus.i_req_valid = 2'b01;
    bus.i_rsp_ready = 2'b01;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.o_rsp_valid !== 2'b10 || bus.o_rsp_data !== 8'h13 || bus.o_rsp_carry !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold %0d: got rsp_valid=%b data=%h carry=%b expected 10/13/0",
                 i, bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_carry);
      end
      checks++;
      if (bus.o_req_ready !== 2'b00 || bus.o_busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure status %0d: got ready=%b busy=%b expected 00/1",
                 i, bus.o_req_ready, bus.o_busy);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.i_rsp_ready = 2'b10;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.o_rsp_valid !== 2'b00 || bus.o_busy !== 1'b0 || bus.o_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL backpressure release: got rsp_valid=%b busy=%b ready=%b expected 00/0/01",
               bus.o_rsp_valid, bus.o_busy, bus.o_req_ready);
    end
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 2'b00;
    last_data  = 8'h13;
    last_carry = 1'b0;
  endtask

  task automatic test_reset_exec();
    bus.i_req_valid = 2'b01;
    bus.i_req_op    = 2'b00;
    bus.i_req_a     = {8'h00, 8'h09};
    bus.i_req_b     = {8'h00, 8'h02};
    bus.i_rsp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_exec pre: got busy=%b expected 1", bus.o_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_rsp_data !== 8'h00 || bus.o_rsp_carry !== 1'b0 || bus.o_busy !== 1'b0 ||
        bus.o_rsp_valid !== 2'b00 || bus.o_req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_exec async: got data=%h carry=%b busy=%b rsp_valid=%b ready=%b expected all zero",
               bus.o_rsp_data, bus.o_rsp_carry, bus.o_busy, bus.o_rsp_valid, bus.o_req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_req_valid = 2'b00;
    last_data  = 8'h00;
    last_carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.o_rsp_valid !== 2'b00 || bus.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_exec aborted %0d: got rsp_valid=%b busy=%b expected 00/0",
                 i, bus.o_rsp_valid, bus.o_busy);
      end
    end
    run_op(1, 1'b1, 8'h84, 8'h86, 8'h8A, 1'b0, "after_reset_add");
  endtask

  task automatic test_fairness();
    bus.i_req_valid = 2'b11;
    bus.i_req_op    = 2'b10;              // req1 add, req0 sub
    bus.i_req_a     = {8'h02, 8'h05};
    bus.i_req_b     = {8'h03, 8'h01};
    bus.i_rsp_ready = 2'b11;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] oh;
      logic [7:0] exp_d;
      oh    = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_d = (i % 2 == 1) ? 8'h05 : 8'h04;
      #1;
      checks++;
      if (bus.o_req_ready !== oh) begin
        errors++;
        $display("FAIL fairness grant %0d: got %b expected %b", i, bus.o_req_ready, oh);
      end
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.o_rsp_valid !== oh || bus.o_rsp_data !== exp_d) begin
        errors++;
        $display("FAIL fairness response %0d: got rsp_valid=%b data=%h expected %b/%h",
                 i, bus.o_rsp_valid, bus.o_rsp_data, oh, exp_d);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic_sub();
    test_add_neg();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_exec();
    test_fairness();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
